// File: rtl/mux2_share_arbiter_4bit.sv
// Two-requester round-robin arbiter sharing one 4-bit mux2 datapath.
// Captures the selected word into a register and presents it with valid/ready.

module mux2_1_4bit (
    input  logic [3:0] in1,
    input  logic [3:0] in2,
    input  logic       s,
    output logic [3:0] y
);

    assign y = s ? in1 : in2;

endmodule

module mux2_share_arbiter_4bit #(
    parameter logic FIRST_PRI = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic [3:0] data0,
    output logic       gnt0,
    input  logic       req1,
    input  logic [3:0] data1,
    output logic       gnt1,
    output logic       sel,
    output logic [3:0] out_data,
    output logic       out_valid,
    input  logic       out_ready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERVE0 = 2'd1,
        SERVE1 = 2'd2
    } state_t;

    state_t     state;
    logic       last_win;
    logic       eff_req0;
    logic       eff_req1;
    logic       win;
    logic       load;
    logic [3:0] mux_y;

    // A requester granted last cycle still shows req; hide it for one cycle
    assign eff_req0 = req0 & ~gnt0;
    assign eff_req1 = req1 & ~gnt1;

    assign out_valid = (state != IDLE);
    assign load      = (~out_valid | out_ready) & (eff_req0 | eff_req1);
    assign sel       = win;

    // Next-winner pick: sole requester wins, otherwise the one not served last
    always_comb begin
        win = 1'b0;
        if (eff_req0 && eff_req1) begin
            win = ~last_win;
        end else if (eff_req1) begin
            win = 1'b1;
        end
    end

    mux2_1_4bit u_mux (
        .in1 (data1),
        .in2 (data0),
        .s   (sel),
        .y   (mux_y)
    );

    // Capture, grant pulse and serve-state tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            out_data <= 4'd0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            last_win <= ~FIRST_PRI;
        end else begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            if (load) begin
                out_data <= mux_y;
                gnt0     <= ~win;
                gnt1     <= win;
                last_win <= win;
                state    <= win ? SERVE1 : SERVE0;
            end else if (out_valid && out_ready) begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_mux2_share_arbiter_4bit.sv
// Bench for mux2_share_arbiter_4bit: reference model compared every cycle
// plus literal expectations for the directed scenarios.

module tb_mux2_share_arbiter_4bit;

    logic       clk;
    logic       rst_n;
    logic       req0;
    logic [3:0] data0;
    logic       gnt0;
    logic       req1;
    logic [3:0] data1;
    logic       gnt1;
    logic       sel;
    logic [3:0] out_data;
    logic       out_valid;
    logic       out_ready;

    int n_cmp;
    int n_bad;

    mux2_share_arbiter_4bit #(.FIRST_PRI(1'b0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .data0     (data0),
        .gnt0      (gnt0),
        .req1      (req1),
        .data1     (data1),
        .gnt1      (gnt1),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: who holds the output word, who was served last
    logic       m_valid;
    logic [3:0] m_data;
    logic       m_gnt0;
    logic       m_gnt1;
    int         m_turn;

    function automatic logic [1:0] m_pending();
        logic [1:0] p;
        p[0] = req0 && !m_gnt0;
        p[1] = req1 && !m_gnt1;
        return p;
    endfunction

    function automatic int m_pick();
        logic [1:0] p;
        p = m_pending();
        if (p == 2'b11) return m_turn;
        if (p == 2'b10) return 1;
        return 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= 4'd0;
            m_gnt0  <= 1'b0;
            m_gnt1  <= 1'b0;
            m_turn  <= 0;
        end else begin
            if ((!m_valid || out_ready) && m_pending() != 2'b00) begin
                m_valid <= 1'b1;
                m_data  <= (m_pick() == 1) ? data1 : data0;
                m_gnt0  <= (m_pick() == 0);
                m_gnt1  <= (m_pick() == 1);
                m_turn  <= 1 - m_pick();
            end else begin
                m_gnt0 <= 1'b0;
                m_gnt1 <= 1'b0;
                if (m_valid && out_ready) m_valid <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [3:0] act,
                       input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_valid", {3'b0, out_valid}, {3'b0, m_valid});
            chk("m_gnt0", {3'b0, gnt0}, {3'b0, m_gnt0});
            chk("m_gnt1", {3'b0, gnt1}, {3'b0, m_gnt1});
            chk("m_sel", {3'b0, sel}, 4'(m_pick()));
            if (m_valid) chk("m_data", out_data, m_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #12;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        req0      = 1'b0;
        req1      = 1'b0;
        data0     = 4'd0;
        data1     = 4'd0;
        out_ready = 1'b0;
        do_reset();

        chk("rst_valid", {3'b0, out_valid}, 4'd0);
        chk("rst_data", out_data, 4'd0);

        // Single request, then release
        req0 = 1'b1; data0 = 4'hA; out_ready = 1'b1;
        tick();
        chk("single_data", out_data, 4'hA);
        chk("single_valid", {3'b0, out_valid}, 4'd1);
        chk("single_gnt0", {3'b0, gnt0}, 4'd1);
        req0 = 1'b0;
        tick();
        chk("single_drop", {3'b0, out_valid}, 4'd0);
        chk("single_gnt0_off", {3'b0, gnt0}, 4'd0);

        // Contention from reset: 0 wins first, then strict alternation
        do_reset();
        req0 = 1'b1; data0 = 4'h3;
        req1 = 1'b1; data1 = 4'hC; out_ready = 1'b1;
        #1;
        chk("cont_sel0", {3'b0, sel}, 4'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("cont_data", out_data, (i % 2 == 0) ? 4'h3 : 4'hC);
            chk("cont_gnt1", {3'b0, gnt1}, 4'(i % 2));
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();
        tick();

        // Backpressure holds the word and withholds gnt1
        out_ready = 1'b0; req0 = 1'b1; data0 = 4'h5;
        tick();
        chk("bp_first", out_data, 4'h5);
        req0 = 1'b0; req1 = 1'b1; data1 = 4'h9;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_hold", out_data, 4'h5);
            chk("bp_no_gnt1", {3'b0, gnt1}, 4'd0);
            chk("bp_sel", {3'b0, sel}, 4'd1);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_release", out_data, 4'h9);
        chk("bp_gnt1", {3'b0, gnt1}, 4'd1);
        req1 = 1'b0;
        tick();
        chk("bp_empty", {3'b0, out_valid}, 4'd0);

        // req0 lingers one cycle past its grant: no second capture
        req0 = 1'b1; data0 = 4'h7;
        tick();
        chk("mask_gnt0", {3'b0, gnt0}, 4'd1);
        tick();
        chk("mask_valid", {3'b0, out_valid}, 4'd0);
        chk("mask_gnt0_off", {3'b0, gnt0}, 4'd0);
        req0 = 1'b0;

        // Idle with toggling ready: nothing moves
        for (int i = 0; i < 4; i++) begin
            out_ready = ~out_ready;
            tick();
            chk("idle_valid", {3'b0, out_valid}, 4'd0);
            chk("idle_data", out_data, 4'h7);
            chk("idle_gnt", {2'b0, gnt1, gnt0}, 4'd0);
        end

        // Mixed traffic obeying hold-until-grant, checked by the model
        for (int i = 0; i < 60; i++) begin
            if (gnt0) req0 = 1'b0;
            else if (!req0 && (i % 3 != 0)) begin
                req0 = 1'b1; data0 = 4'(i);
            end
            if (gnt1) req1 = 1'b0;
            else if (!req1 && (i % 5 != 2)) begin
                req1 = 1'b1; data1 = 4'(15 - i);
            end
            out_ready = (i % 4 != 3) && (i % 7 != 5);
            tick();
        end

        // Reset mid-SERVE1 clears outputs immediately
        req0 = 1'b0; req1 = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0; req1 = 1'b1; data1 = 4'hE;
        tick();
        chk("s1_data", out_data, 4'hE);
        chk("s1_gnt1", {3'b0, gnt1}, 4'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {3'b0, out_valid}, 4'd0);
        chk("arst_gnt", {2'b0, gnt1, gnt0}, 4'd0);
        chk("arst_data", out_data, 4'd0);
        req1 = 1'b0;
        #20;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        tick();
        chk("post_rst_valid", {3'b0, out_valid}, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
                 n_bad);
        $finish;
    end

endmodule
